embed_onchip_ram_ctl: RTL and testbench
=======================================

Name: embed_onchip_ram_ctl

Overview:
Parametrised on-chip RAM slave for the Embed Avalon-MM fabric. It is the successor to the fixed 32x4096 single-port RAM. It adds:
- configurable width and depth
- optional output register
- explicit read/readdatavalid/waitrequest handshake
- a hardware zero-fill engine that clears the array after reset

It sits behind the interconnect as program/data memory for the soft CPU and is built on an inferred byte-enabled block RAM.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 12, word-address width; depth = 2**ADDR_W words.
- OUT_REG, 0, 0 = read latency 1; 1 = extra output register, read latency 2.
- CLEAR_ON_RESET, 1, 1 = zero-fill the whole array after reset before accepting commands; 0 = no clear.

Ports:
- clk  in  1  single system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  byte lanes for writes; ignored for reads.
- chipselect  in  1  slave select.
- read  in  1  read request (qualified by chipselect).
- write  in  1  write request (qualified by chipselect).
- writedata  in  DATA_W  write data.
- clken  in  1  clock enable; 0 stalls the block.
- readdata  out  DATA_W  read data, valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.
- waitrequest  out  1  1 = command not accepted this cycle.
- busy  out  1  1 while the clear engine runs.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - readdata=0, readdatavalid=0, all pipeline valid bits=0, clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET=1, else READY.
  - waitrequest=1 and busy=CLEAR_ON_RESET while in reset.
  - Array contents are not touched by reset itself.
- FSM has two states: CLEAR and READY.
  - CLEAR: each cycle with clken=1, write 0 to all byte lanes at word clr_cnt, then increment clr_cnt.
  - After writing word 2**ADDR_W-1, go to READY on the next edge (clear takes exactly 2**ADDR_W enabled cycles).
  - In CLEAR: busy=1, waitrequest=1; bus commands are ignored and not queued.
  - READY is terminal until the next reset.
  - reset_n asserted mid-clear: clear restarts from word 0 after release.
- Acceptance:
  - waitrequest = (state==CLEAR) | ~clken; purely combinational.
  - A command is accepted when chipselect & (read|write) & ~waitrequest.
- Write:
  - Accepted write updates only the lanes with byteenable[i]=1 at the accepting edge.
  - byteenable=0 writes nothing.
- Read:
  - Synchronous array read; no wait states.
  - OUT_REG=0: readdata/readdatavalid are presented in the cycle after acceptance (latency 1).
  - OUT_REG=1: presented in the second cycle after acceptance (latency 2).
  - Back-to-back reads give one readdatavalid per read, in order; full throughput of 1 per cycle.
- Read and write asserted together: illegal. The block performs the write and drops the read (no readdatavalid).
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data. A read in the same cycle as a write is excluded by the rule above.
- readdata holds its last value when readdatavalid=0.
- clken=0:
  - No array access.
  - Pipeline registers and clr_cnt hold.
  - readdatavalid forced to 0.
  - A pending stage is presented on the first cycle clken returns to 1. No data is lost or duplicated.
- Address arithmetic:
  - clr_cnt is ADDR_W+1 bits; bit ADDR_W set marks completion.
  - Bus address is used unmodified; there is no wrap logic, since the full range is exactly covered.

Test Plan:
- CLEAR_ON_RESET=1, ADDR_W=4: release reset -> busy=1 and waitrequest=1 for exactly 16 cycles, then 0; reading words 0..15 returns 0x00000000.
- OUT_REG=0: write 0xDEADBEEF @5 with byteenable=4'b1111, then read @5 -> readdatavalid pulses 1 cycle after acceptance with readdata=0xDEADBEEF. Repeat with OUT_REG=1 -> pulse 2 cycles after acceptance.
- Byte lanes: preload 0x11223344 @2, write 0xAABBCCDD with byteenable=4'b0101 -> read returns 0x11BB33DD.
- Back-to-back reads of @0..@3 holding 0xA0..0xA3 with clken dropped for 3 cycles mid-stream -> exactly 4 readdatavalid pulses, data in order, none while clken=0.
- Assert reset_n=0 at clear word 7 (ADDR_W=4), release -> full 16-cycle clear restarts from word 0.
- read=1 and write=1 together at @9 with data 0x5 -> @9=0x5, no readdatavalid; a following read of @9 returns 0x5.

Source files
------------

// File: rtl/embed_onchip_ram_ctl.sv
`default_nettype none
// ============================================================================
// Module   : embed_onchip_ram_ctl
// Brief    : Avalon-MM on-chip RAM slave with byte lanes, optional output
//            register and a post-reset zero-fill engine.
// Revision : 1.0
// ============================================================================
module embed_onchip_ram_ctl #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 12,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic                chipselect,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                clken,
  output logic [DATA_W-1:0]   readdata,
  output logic                readdatavalid,
  output logic                waitrequest,
  output logic                busy
);

  localparam int c_lanes = DATA_W / 8;
  localparam int c_depth = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  localparam state_t c_rst_state = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_READY;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W:0]     r_clr_cnt;
  logic [ADDR_W:0]     w_clr_cnt_nxt;
  logic                w_clear_we;
  logic [DATA_W-1:0]   r_mem [c_depth];
  logic                w_cmd;
  logic                w_wr;
  logic                w_rd;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_wdata;
  logic [c_lanes-1:0]  w_mem_be;
  logic                r_v1;
  logic [DATA_W-1:0]   r_d1;
  logic                w_v_out;

  assign waitrequest = ~reset_n | (r_state == S_CLEAR) | ~clken;
  assign busy        = (r_state == S_CLEAR);

  // Simultaneous read+write is treated as a write only.
  assign w_cmd = chipselect & ~waitrequest;
  assign w_wr  = w_cmd & write;
  assign w_rd  = w_cmd & read & ~write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= c_rst_state;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    w_clear_we    = 1'b0;
    if (r_state == S_CLEAR && clken) begin
      w_clear_we    = 1'b1;
      w_clr_cnt_nxt = r_clr_cnt + (ADDR_W + 1)'(1);
      if (w_clr_cnt_nxt[ADDR_W]) begin
        w_state_nxt = S_READY;
      end
    end
  end

  // The clear engine must not touch the array while reset is held.
  assign w_mem_be    = (w_clear_we && reset_n) ? {c_lanes{1'b1}} :
                       (w_wr ? byteenable : {c_lanes{1'b0}});
  assign w_mem_addr  = w_clear_we ? r_clr_cnt[ADDR_W-1:0] : address;
  assign w_mem_wdata = w_clear_we ? {DATA_W{1'b0}} : writedata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < c_lanes; i++) begin
      if (w_mem_be[i]) begin
        r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_v1 <= 1'b0;
      r_d1 <= '0;
    end else if (clken) begin
      r_v1 <= w_rd;
      if (w_rd) begin
        r_d1 <= r_mem[address];
      end
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic              r_v2;
      logic [DATA_W-1:0] r_d2;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else if (clken) begin
          r_v2 <= r_v1;
          if (r_v1) begin
            r_d2 <= r_d1;
          end
        end
      end

      assign readdata = r_d2;
      assign w_v_out  = r_v2;
    end else begin : g_no_out_reg
      assign readdata = r_d1;
      assign w_v_out  = r_v1;
    end
  endgenerate

  // A held stage is only presented once clken returns.
  assign readdatavalid = w_v_out & clken;

endmodule
`default_nettype wire

// File: tb/tb_embed_onchip_ram_ctl.sv
`default_nettype none
// Bench for embed_onchip_ram_ctl: two instances (latency 1 and 2) share one
// stimulus stream and are checked against a word-array / response-list model.
module tb_embed_onchip_ram_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic [3:0]  byteenable;
  logic        chipselect;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic        clken;
  logic [31:0] rdata0, rdata1;
  logic        rdv0, rdv1, wait0, wait1, busy0, busy1;

  always #5 clk = ~clk;

  embed_onchip_ram_ctl #(.DATA_W(32), .ADDR_W(4), .OUT_REG(0), .CLEAR_ON_RESET(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdata0), .readdatavalid(rdv0), .waitrequest(wait0),
    .busy(busy0)
  );

  embed_onchip_ram_ctl #(.DATA_W(32), .ADDR_W(4), .OUT_REG(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .byteenable(byteenable),
    .chipselect(chipselect), .read(read), .write(write), .writedata(writedata),
    .clken(clken), .readdata(rdata1), .readdatavalid(rdv1), .waitrequest(wait1),
    .busy(busy1)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } op_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [16];
  int          clr_rem;
  int          ecnt;
  logic [31:0] rq_data [$];
  int          rq_k [$];
  int          h0, h1;
  bit          cap;
  logic [31:0] cap0 [$];
  logic [31:0] cap1 [$];
  op_t         tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Response k (accepted at enabled edge rq_k) is due in the enabled cycle
  // where lat-1 further enabled edges have passed.
  task automatic check_port(input int d, input logic v, input logic [31:0] dat,
                            input int lat, inout int h);
    logic e;
    e = 1'b0;
    if (clken && h < rq_k.size()) e = (rq_k[h] + lat - 1 == ecnt);
    chk(d == 0 ? "valid0" : "valid1", {31'd0, v}, {31'd0, e});
    if (e) begin
      chk(d == 0 ? "rdata0" : "rdata1", dat, rq_data[h]);
      if (cap) begin
        if (d == 0) cap0.push_back(dat);
        else cap1.push_back(dat);
      end
      h++;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_rdata0", rdata0, 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_valid0", {31'd0, rdv0}, 32'd0);
        chk("rst_valid1", {31'd0, rdv1}, 32'd0);
        chk("rst_wait0", {31'd0, wait0}, 32'd1);
        chk("rst_busy1", {31'd0, busy1}, 32'd1);
        clr_rem = 16;
        h0 = rq_k.size();
        h1 = rq_k.size();
      end else begin
        chk("wait0", {31'd0, wait0}, {31'd0, (clr_rem > 0) || !clken});
        chk("wait1", {31'd0, wait1}, {31'd0, (clr_rem > 0) || !clken});
        chk("busy0", {31'd0, busy0}, {31'd0, clr_rem > 0});
        chk("busy1", {31'd0, busy1}, {31'd0, clr_rem > 0});
        check_port(0, rdv0, rdata0, 1, h0);
        check_port(1, rdv1, rdata1, 2, h1);
        if (clken) begin
          ecnt++;
          if (clr_rem > 0) begin
            mem[16 - clr_rem] = 32'h0;
            clr_rem--;
          end else if (chipselect && write) begin
            for (int i = 0; i < 4; i++)
              if (byteenable[i]) mem[address][8*i +: 8] = writedata[8*i +: 8];
          end else if (chipselect && read) begin
            rq_data.push_back(mem[address]);
            rq_k.push_back(ecnt);
          end
        end
      end
    end
  end

  task automatic idle();
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic count_busy(input string nm);
    int nb0, nb1, nw0;
    nb0 = 0; nb1 = 0; nw0 = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      nb0 += int'(busy0);
      nb1 += int'(busy1);
      nw0 += int'(wait0);
    end
    chk({nm, "_busy0"}, nb0, 16);
    chk({nm, "_busy1"}, nb1, 16);
    chk({nm, "_wait0"}, nw0, 16);
  endtask

  task automatic do_op(input int id, input op_t o);
    int v0, v1;
    logic [31:0] d0, d1;
    @(posedge clk); #1;
    chipselect = 1'b1; read = o.rd; write = o.wr; address = o.addr;
    byteenable = o.be; writedata = o.wdata; clken = 1'b1;
    @(posedge clk); #1;
    idle();
    v0 = -1; v1 = -1; d0 = '0; d1 = '0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (rdv0 && v0 < 0) begin v0 = k; d0 = rdata0; end
      if (rdv1 && v1 < 0) begin v1 = k; d1 = rdata1; end
    end
    if (o.rd && !o.wr) begin
      chk($sformatf("op%0d_lat0", id), v0, 1);
      chk($sformatf("op%0d_data0", id), d0, o.exp);
      chk($sformatf("op%0d_lat1", id), v1, 2);
      chk($sformatf("op%0d_data1", id), d1, o.exp);
    end else begin
      chk($sformatf("op%0d_novalid0", id), v0, -1);
      chk($sformatf("op%0d_novalid1", id), v1, -1);
    end
  endtask

  initial begin
    op_t o;
    tbl[0]  = '{1'b0, 1'b1, 4'd5, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 4'd5, 4'hF, 32'h0,        32'hDEADBEEF};
    tbl[2]  = '{1'b0, 1'b1, 4'd2, 4'hF, 32'h11223344, 32'h0};
    tbl[3]  = '{1'b0, 1'b1, 4'd2, 4'h5, 32'hAABBCCDD, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 4'd2, 4'hF, 32'h0,        32'h11BB33DD};
    tbl[5]  = '{1'b0, 1'b1, 4'd0, 4'hF, 32'hA0,       32'h0};
    tbl[6]  = '{1'b0, 1'b1, 4'd1, 4'hF, 32'hA1,       32'h0};
    tbl[7]  = '{1'b0, 1'b1, 4'd2, 4'hF, 32'hA2,       32'h0};
    tbl[8]  = '{1'b0, 1'b1, 4'd3, 4'hF, 32'hA3,       32'h0};
    tbl[9]  = '{1'b1, 1'b1, 4'd9, 4'hF, 32'h5,        32'h0};
    tbl[10] = '{1'b1, 1'b0, 4'd9, 4'hF, 32'h0,        32'h5};
    tbl[11] = '{1'b0, 1'b1, 4'd7, 4'h0, 32'hFFFFFFFF, 32'h0};
    tbl[12] = '{1'b1, 1'b0, 4'd7, 4'hF, 32'h0,        32'h0};

    reset_n = 1'b1; address = '0; byteenable = '0; writedata = '0;
    idle();
    cap = 1'b0; clr_rem = 16; ecnt = 0; h0 = 0; h1 = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    count_busy("clear_len");

    for (int w = 0; w < 16; w++) begin
      o = '{1'b1, 1'b0, 4'(w), 4'hF, 32'h0, 32'h0};
      do_op(100 + w, o);
    end

    for (int i = 0; i < 13; i++) do_op(i, tbl[i]);

    // Back-to-back reads of 0..3 with a 3-cycle clken gap after the second.
    cap = 1'b1;
    @(posedge clk); #1 chipselect = 1'b1; read = 1'b1; address = 4'd0;
    @(posedge clk); #1 address = 4'd1;
    @(posedge clk); #1 address = 4'd2; clken = 1'b0;
    repeat (3) @(posedge clk);
    #1 clken = 1'b1;
    @(posedge clk); #1 address = 4'd3;
    @(posedge clk); #1 idle();
    repeat (5) @(negedge clk);
    cap = 1'b0;
    chk("b2b_n0", cap0.size(), 4);
    chk("b2b_n1", cap1.size(), 4);
    for (int i = 0; i < 4 && i < cap0.size(); i++) chk("b2b_d0", cap0[i], 32'hA0 + i);
    for (int i = 0; i < 4 && i < cap1.size(); i++) chk("b2b_d1", cap1[i], 32'hA0 + i);

    for (int n = 0; n < 500; n++) begin
      int r;
      @(posedge clk); #1;
      r          = int'($urandom_range(0, 7));
      clken      = ($urandom_range(0, 9) != 0);
      chipselect = ($urandom_range(0, 3) != 0);
      read       = (r < 4);
      write      = (r >= 3 && r < 7);
      address    = 4'($urandom_range(0, 15));
      byteenable = 4'($urandom);
      writedata  = $urandom;
    end
    @(posedge clk); #1 idle();
    repeat (4) @(posedge clk);

    // Dirty the array, then reset mid-clear at word 7: clear must restart at 0.
    for (int w = 0; w < 16; w++) begin
      o = '{1'b0, 1'b1, 4'(w), 4'hF, 32'hFFFFFFFF, 32'h0};
      do_op(200 + w, o);
    end
    do_reset();
    repeat (6) @(posedge clk);
    do_reset();
    count_busy("clear_restart");
    for (int w = 0; w < 16; w++) begin
      o = '{1'b1, 1'b0, 4'(w), 4'hF, 32'h0, 32'h0};
      do_op(300 + w, o);
    end

    repeat (4) @(negedge clk);
    chk("drain0", h0, rq_k.size());
    chk("drain1", h1, rq_k.size());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
